dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Shares the single read/write port of the data BRAM between two bus masters: requester 0 (debug module) and requester 1 (DMA/loader engine). It grants whole bursts of 1–16 consecutive words, generates per-beat word addresses, and forwards byte write enables. It also returns read data aligned to the BRAM's one-cycle synchronous read latency. It sits between the masters and the BRAM's second port; the CPU port is not touched.

## Interface
- No parameters; widths fixed: word address 30 bits ([31:2]), data 32 bits, burst length 4 bits.
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- reqN (N=0,1)  in  1  burst request, held until final beat granted
- addrN  in  [31:2]  burst base word address, stable while reqN high
- weN  in  4  byte write enables for whole burst (0 = read burst)
- lenN  in  4  beats minus one (0 → 1 beat, 15 → 16 beats)
- wdataN  in  32  write data for current beat
- gntN  out  1  current beat of requester N is on the RAM port this cycle
- rvalidN  out  1  rdataN holds read data of the beat granted previous cycle
- rdataN  out  32  read data (valid only with rvalidN)
- ram_addr  out  [31:2]  BRAM port address
- ram_we  out  4  BRAM port byte write enables
- ram_din  out  32  BRAM port write data
- ram_dout  in  32  BRAM port read data (registered in BRAM, 1-cycle latency)

## Operation
- States: IDLE, BURST. Registers: state, owner (1 bit), base (30 bits), we_l (4), len_l (4), beat (4), rvalid pipeline (2×1), rr pointer (1, only with macro).
- IDLE: if any req at clock edge → pick winner, latch addr/we/len of winner, beat←0, owner←winner, state←BURST. No req → stay IDLE.
- BURST: gnt[owner]=1, ram_addr=base+beat (30-bit add, wraps 0x3FFFFFFF→0), ram_we=we_l, ram_din=wdata[owner] (live, combinational). At each edge beat←beat+1; when beat==len_l → state←IDLE.
- IDLE outputs: gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_din=0.
- ram_we forced to 0 combinationally whenever rst_n=0: no BRAM write in any reset cycle.
- Read return: rvalidN registered = (state==BURST & owner==N & we_l==0); rdataN = ram_dout when rvalidN, else 0.
- Partial we (e.g. 4'b0010) passes untouched; byte merging is done by the BRAM.
- Out-of-range addresses (above 16 KiB) not checked here; BRAM returns 0 and ignores writes.
- Requester rules: hold addr/we/len stable from req rise until first gnt; present wdata for beat k in the cycle gnt is high, advance after that edge; deassert req the cycle after the final gnt unless a new burst is wanted.
- Requests are only sampled in IDLE; a request arriving during another's burst waits.

## Timing
- Reset values: state IDLE, all gnt/rvalid 0, rdata 0, ram_* 0, beat 0, rr pointer 0.
- Arbitration latency: req high at edge E0 → gnt high cycle E0..E1.
- Read latency: gnt cycle k → rvalid/rdata in cycle k+1.
- Burst of L+1 beats occupies L+1 consecutive gnt cycles; ≥1 IDLE cycle between bursts (peak (L+1)/(L+2) utilisation).
- Reset mid-burst: next cycle IDLE, gnt 0, rvalid 0; remaining beats dropped, beat in reset cycle not written.
- Simultaneous req0/req1 in IDLE: resolved by arbitration policy below.

## Configuration
- DRAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention.
- DRAM_ARB_RR_EN defined: round-robin; on contention the requester not granted last wins; pointer updates on each grant, reset favours requester 0.

## Test plan
- Single read: ram[0x10]=0xDEADBEEF, req0 addr 0x10 len 0 we 0 → gnt0 one cycle, rvalid0 next cycle with rdata0=0xDEADBEEF.
- Burst write: req1 addr 0x20 len 3 we 4'hF data 1,2,3,4 → ram_addr 0x20..0x23 on 4 gnt cycles; read-back burst returns 1,2,3,4 on 4 consecutive rvalid1 cycles.
- Contention: req0 and req1 both, len 0, held → fixed: 0,0,0 granted; with DRAM_ARB_RR_EN: 0,1,0,1 alternating.
- Byte write: word 0x12345678, we 4'b0010 wdata 0x0000AB00 → read back 0x1234AB78.
- Reset mid-burst: write len 7, rst_n low at beat 2 for 1 cycle → words at beats 0–1 written, beat 2 onward unchanged, gnt/rvalid 0 after reset.
- Wrap: addr 0x3FFFFFFF len 1 read → ram_addr 0x3FFFFFFF then 0x0; first rdata 0 (out of range), second = ram[0].

Source files
------------

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-master burst arbiter for the data BRAM second port
// Optional DRAM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module dram_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:2] addr0,
  input  logic [3:0]  we0,
  input  logic [3:0]  len0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic [31:2] addr1,
  input  logic [3:0]  we1,
  input  logic [3:0]  len1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:2] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state;
  logic        owner;
  logic [31:2] base;
  logic [3:0]  we_l;
  logic [3:0]  len_l;
  logic [3:0]  beat;
  logic        rv0_q;
  logic        rv1_q;
  logic        winner;
  logic        busy;

`ifdef DRAM_ARB_RR_EN
  // rr holds the requester preferred on the next contention
  logic        rr;

  always_comb begin
    winner = req1;
    if (req0 && req1) winner = rr;
  end
`else
  always_comb begin
    winner = !req0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      base  <= '0;
      we_l  <= 4'd0;
      len_l <= 4'd0;
      beat  <= 4'd0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      rr    <= 1'b0;
`endif
    end else begin
      // BRAM read data arrives one cycle after the beat was on the port
      rv0_q <= (state == BURST) && !owner && (we_l == 4'd0);
      rv1_q <= (state == BURST) &&  owner && (we_l == 4'd0);
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= winner;
            base  <= winner ? addr1 : addr0;
            we_l  <= winner ? we1   : we0;
            len_l <= winner ? len1  : len0;
            beat  <= 4'd0;
            state <= BURST;
`ifdef DRAM_ARB_RR_EN
            rr    <= !winner;
`endif
          end
        end
        BURST: begin
          beat <= beat + 4'd1;
          if (beat == len_l) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == BURST);
  assign gnt0     = busy && !owner;
  assign gnt1     = busy &&  owner;
  assign ram_addr = busy ? (base + {26'd0, beat}) : '0;
  // no BRAM write may slip through while reset is asserted
  assign ram_we   = (busy && rst_n) ? we_l : 4'd0;
  assign ram_din  = busy ? (owner ? wdata1 : wdata0) : 32'd0;
  assign rvalid0  = rv0_q;
  assign rvalid1  = rv1_q;
  assign rdata0   = rv0_q ? ram_dout : 32'd0;
  assign rdata1   = rv1_q ? ram_dout : 32'd0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [29:0] addr0, addr1;
  logic [3:0]  we0, we1, len0, len1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [29:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;

  logic [29:0] cap_addr [16];
  logic [3:0]  cap_we   [16];
  logic [31:0] cap_din  [16];
  logic [31:0] cap_rd   [16];
  int          rv_it    [16];
  logic [31:0] wdat     [17];
  int          n_g, n_rv, lat, oth;
  bit          tmo;

  always #5 clk = ~clk;

  dram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .we0(we0), .len0(len0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .we1(we1), .len1(len1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  // 16 KiB BRAM model, registered read, out-of-range reads 0 and drops writes
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (ram_addr < 30'd4096) begin
      if (ram_we != 4'd0) mem[ram_addr[11:0]] <= merge(mem[ram_addr[11:0]], ram_din, ram_we);
      ram_dout <= mem[ram_addr[11:0]];
    end else begin
      ram_dout <= 32'd0;
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // drives one burst for requester who and records what appears on the port
  task automatic burst(input bit who, input logic [29:0] a, input logic [3:0] w, input logic [3:0] l);
    int last;
    bit done;
    n_g = 0; n_rv = 0; lat = -1; oth = 0; last = -10; done = 1'b0;
    @(posedge clk); #1;
    if (!who) begin req0 = 1'b1; addr0 = a; we0 = w; len0 = l; wdata0 = wdat[0]; end
    else      begin req1 = 1'b1; addr1 = a; we1 = w; len1 = l; wdata1 = wdat[0]; end
    for (int it = 0; it < 40 && !done; it++) begin
      @(negedge clk);
      if ((who ? gnt0 : gnt1)) oth++;
      if ((who ? gnt1 : gnt0) && n_g < 16) begin
        if (n_g == 0) lat = it;
        cap_addr[n_g] = ram_addr; cap_we[n_g] = ram_we; cap_din[n_g] = ram_din;
        n_g++; last = it;
      end
      if ((who ? rvalid1 : rvalid0) && n_rv < 16) begin
        cap_rd[n_rv] = who ? rdata1 : rdata0; rv_it[n_rv] = it; n_rv++;
      end
      if (n_g == int'(l) + 1 && it == last + 1) done = 1'b1;
      @(posedge clk); #1;
      if (!who) wdata0 = wdat[n_g]; else wdata1 = wdat[n_g];
      if (n_g == int'(l) + 1) begin
        if (!who) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    tmo = !done;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; addr0 = 30'h5; we0 = 4'hF; len0 = 4'd3;
    repeat (3) @(negedge clk);
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", rvalid0, rvalid1); end
    checks++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0", rdata0, rdata1); end
    checks++; if (ram_addr !== 30'd0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
    checks++; if (ram_we !== 4'd0) begin errors++; $display("FAIL reset_ram_we: got %h expected 0", ram_we); end
    checks++; if (ram_din !== 32'd0) begin errors++; $display("FAIL reset_ram_din: got %h expected 0", ram_din); end
    @(posedge clk); #1;
    req0 = 1'b0; we0 = 4'd0; len0 = 4'd0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_release_gnt0: got %b expected 0", gnt0); end
  endtask

  task automatic test_single_read();
    poke(12'h010, 32'hDEADBEEF);
    wdat[0] = 32'd0;
    burst(1'b0, 30'h10, 4'd0, 4'd0);
    checks++; if (tmo) begin errors++; $display("FAIL single_timeout: got timeout expected completion"); end
    checks++; if (n_g !== 1) begin errors++; $display("FAIL single_gnt_count: got %0d expected 1", n_g); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
    checks++; if (cap_addr[0] !== 30'h10) begin errors++; $display("FAIL single_addr: got %h expected 10", cap_addr[0]); end
    checks++; if (cap_we[0] !== 4'd0) begin errors++; $display("FAIL single_we: got %h expected 0", cap_we[0]); end
    checks++; if (n_rv !== 1) begin errors++; $display("FAIL single_rvalid_count: got %0d expected 1", n_rv); end
    checks++; if (rv_it[0] !== lat + 1) begin errors++; $display("FAIL single_rvalid_time: got %0d expected %0d", rv_it[0], lat + 1); end
    checks++; if (cap_rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", cap_rd[0]); end
    @(negedge clk);
    checks++; if (ram_addr !== 30'd0 || ram_din !== 32'd0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL idle_outputs: got addr %h din %h gnt0 %b expected 0 0 0", ram_addr, ram_din, gnt0); end
  endtask

  task automatic test_burst_write();
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    wdat[4] = 32'd0;
    burst(1'b1, 30'h20, 4'hF, 4'd3);
    checks++; if (tmo) begin errors++; $display("FAIL bw_timeout: got timeout expected completion"); end
    checks++; if (n_g !== 4) begin errors++; $display("FAIL bw_gnt_count: got %0d expected 4", n_g); end
    checks++; if (n_rv !== 0 || oth !== 0) begin errors++; $display("FAIL bw_spurious: got rvalid %0d other gnt %0d expected 0 0", n_rv, oth); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_addr[i] !== 30'(32'h20 + i)) begin errors++; $display("FAIL bw_addr%0d: got %h expected %h", i, cap_addr[i], 32'h20 + i); end
      checks++; if (cap_din[i] !== 32'(i + 1) || cap_we[i] !== 4'hF) begin errors++; $display("FAIL bw_din%0d: got %h we %h expected %h we f", i, cap_din[i], cap_we[i], i + 1); end
      checks++; if (mem[12'h20 + 12'(i)] !== 32'(i + 1)) begin errors++; $display("FAIL bw_mem%0d: got %h expected %h", i, mem[12'h20 + 12'(i)], i + 1); end
    end
    for (int i = 0; i < 5; i++) wdat[i] = 32'd0;
    burst(1'b1, 30'h20, 4'd0, 4'd3);
    checks++; if (n_rv !== 4) begin errors++; $display("FAIL br_rvalid_count: got %0d expected 4", n_rv); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_rd[i] !== 32'(i + 1)) begin errors++; $display("FAIL br_rdata%0d: got %h expected %h", i, cap_rd[i], i + 1); end
      checks++; if (rv_it[i] !== lat + 1 + i) begin errors++; $display("FAIL br_rvalid_time%0d: got %0d expected %0d", i, rv_it[i], lat + 1 + i); end
    end
  endtask

  task automatic test_byte_write();
    poke(12'h030, 32'h12345678);
    wdat[0] = 32'h0000AB00; wdat[1] = 32'd0;
    burst(1'b0, 30'h30, 4'b0010, 4'd0);
    checks++; if (cap_we[0] !== 4'b0010) begin errors++; $display("FAIL byte_we: got %b expected 0010", cap_we[0]); end
    wdat[0] = 32'd0;
    burst(1'b0, 30'h30, 4'd0, 4'd0);
    checks++; if (n_rv !== 1 || cap_rd[0] !== 32'h1234AB78) begin errors++; $display("FAIL byte_readback: got %h (n %0d) expected 1234ab78", cap_rd[0], n_rv); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_seq;
    logic [7:0] seq;
    int k, both;
`ifdef DRAM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    seq = 8'd0; k = 0; both = 0;
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 30'h10; we0 = 4'd0; len0 = 4'd0;
    req1 = 1'b1; addr1 = 30'h20; we1 = 4'd0; len1 = 4'd0;
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if ((gnt0 || gnt1) && k < 8) begin seq[k] = gnt1; k++; end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    checks++; if (k !== 6) begin errors++; $display("FAIL cont_grants: got %0d expected 6", k); end
    checks++; if (both !== 0) begin errors++; $display("FAIL cont_double_gnt: got %0d expected 0", both); end
    checks++; if (seq[3:0] !== exp_seq) begin errors++; $display("FAIL cont_order: got %b expected %b", seq[3:0], exp_seq); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) poke(12'h040 + 12'(i), 32'hA0 + 32'(i));
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 30'h40; we0 = 4'hF; len0 = 4'd7; wdata0 = 32'h1000;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || ram_addr !== 30'h40) begin errors++; $display("FAIL rmb_beat0: got gnt %b addr %h expected 1 40", gnt0, ram_addr); end
    @(posedge clk); #1;
    wdata0 = 32'h1001;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || ram_addr !== 30'h41) begin errors++; $display("FAIL rmb_beat1: got gnt %b addr %h expected 1 41", gnt0, ram_addr); end
    @(posedge clk); #1;
    wdata0 = 32'h1002; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ram_we !== 4'd0) begin errors++; $display("FAIL rmb_we_in_reset: got %h expected 0", ram_we); end
    @(posedge clk); #1;
    rst_n = 1'b1; req0 = 1'b0; we0 = 4'd0; len0 = 4'd0;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rmb_after_reset: got gnt %b%b rvalid %b%b expected 0000", gnt0, gnt1, rvalid0, rvalid1); end
    repeat (2) @(negedge clk);
    checks++; if (mem[12'h040] !== 32'h1000 || mem[12'h041] !== 32'h1001) begin
      errors++; $display("FAIL rmb_written: got %h %h expected 1000 1001", mem[12'h040], mem[12'h041]); end
    for (int i = 2; i < 8; i++) begin
      checks++; if (mem[12'h040 + 12'(i)] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL rmb_untouched%0d: got %h expected %h", i, mem[12'h040 + 12'(i)], 32'hA0 + i); end
    end
  endtask

  task automatic test_wrap();
    poke(12'h000, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) wdat[i] = 32'd0;
    burst(1'b1, 30'h3FFFFFFF, 4'd0, 4'd1);
    checks++; if (tmo || n_g !== 2) begin errors++; $display("FAIL wrap_gnt_count: got %0d (timeout %b) expected 2", n_g, tmo); end
    checks++; if (cap_addr[0] !== 30'h3FFFFFFF || cap_addr[1] !== 30'h0) begin
      errors++; $display("FAIL wrap_addr: got %h %h expected 3fffffff 0", cap_addr[0], cap_addr[1]); end
    checks++; if (n_rv !== 2 || cap_rd[0] !== 32'd0 || cap_rd[1] !== 32'hCAFE0001) begin
      errors++; $display("FAIL wrap_rdata: got %h %h (n %0d) expected 0 cafe0001", cap_rd[0], cap_rd[1], n_rv); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; addr0 = '0; we0 = '0; len0 = '0; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; we1 = '0; len1 = '0; wdata1 = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 17; i++) wdat[i] = 32'd0;
    test_reset();
    test_single_read();
    test_burst_write();
    test_byte_write();
    test_contention();
    test_reset_mid_burst();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
